instr_fetch_queue: RTL and testbench

//  Fetch stage sitting directly upstream of the decoder/register-file datapath. It owns the PC,

---
 rtl/instr_fetch_queue.sv | 106 ++++++++++
 tb/tb_instr_fetch_queue.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Fetch stage ahead of decode. Owns the fetch PC and issues in-order word
//   reads to instruction memory. Returned words are buffered with their PC in
//   a DEPTH-entry circular queue and handed downstream over valid/ready.
//   A redirect flushes the queue and restarts fetch at the target. Responses
//   for requests issued before the redirect are counted and dropped.
// Ports
//   clk_i, rst_i                 clock, synchronous active-low reset
//   mem_req_o/addr_o/gnt_i       request channel (transfer on req & gnt)
//   mem_rvalid_i/rdata_i         in-order read responses
//   redirect_i/redirect_pc_i     flush and restart fetch
//   instr_o/pc_o/pc4_o/valid_o   queue head, valid when the queue is non-empty
//   ready_i                      consumer takes the head on valid_o & ready_i
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;   // counters reach DEPTH itself

  logic [31:0]   fetch_pc_q, resp_pc_q;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pcq_q   [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, outst_q, disc_q;

  logic [CW:0]   credits;
  logic          fire, pop, rsp_drop, rsp_push, rsp_any;
  logic [31:0]   redir_pc;

  // Every slot is reserved at issue time: queued + in flight + stale <= DEPTH,
  // so a push can never find the queue full.
  assign credits   = {1'b0, count_q} + {1'b0, outst_q} + {1'b0, disc_q};
  // rst_i gates the request so nothing is issued while reset is asserted.
  assign mem_req_o = rst_i & ~redirect_i & (credits < (CW+1)'(DEPTH));
  assign mem_addr_o = fetch_pc_q;
  assign fire      = mem_req_o & mem_gnt_i;

  assign valid_o = (count_q != '0);
  assign instr_o = instr_q[rd_ptr_q];
  assign pc_o    = pcq_q[rd_ptr_q];
  assign pc4_o   = pcq_q[rd_ptr_q] + 32'd4;
  assign pop     = valid_o & ready_i;

  // Stale responses are consumed first; a response with nothing pending is
  // a protocol error and is ignored.
  assign rsp_drop = mem_rvalid_i & (disc_q != '0);
  assign rsp_push = mem_rvalid_i & (disc_q == '0) & (outst_q != '0);
  assign rsp_any  = mem_rvalid_i & ((disc_q != '0) | (outst_q != '0));
  assign redir_pc = redirect_pc_i & ~32'h3;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      disc_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pcq_q[i]   <= '0;
      end
    end else if (redirect_i) begin
      fetch_pc_q <= redir_pc;
      resp_pc_q  <= redir_pc;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      // Everything still in flight becomes stale; a response landing in this
      // very cycle retires one of them immediately.
      disc_q     <= disc_q + outst_q - CW'(rsp_any);
    end else begin
      if (fire) fetch_pc_q <= fetch_pc_q + 32'd4;
      outst_q <= outst_q + CW'(fire) - CW'(rsp_push);
      disc_q  <= disc_q - CW'(rsp_drop);
      if (rsp_push) begin
        instr_q[wr_ptr_q] <= mem_rdata_i;
        pcq_q[wr_ptr_q]   <= resp_pc_q;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
        resp_pc_q         <= resp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(rsp_push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue. An in-order memory model with
// per-request latency answers fetches with word = addr>>2. A queue-based
// reference model applies the fetch/redirect/discard rules and every cycle
// the DUT outputs are compared against it.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        mem_req_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_addr_o, mem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] instr_o, pc_o, pc4_o;
  logic        valid_o, ready_i = 1'b0;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_dut (
    .clk_i(clk), .rst_i(rst_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc4_o(pc4_o), .valid_o(valid_o),
    .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  ent_t        q[$];
  mreq_t       mq[$];
  logic [31:0] m_fpc, m_rpc;
  int          m_out, m_disc, cyc_n = 0, last_due = 0;
  bit          inited = 0, just_rst = 0;
  int          nfire = 0;   // DUT-observed request handshakes

  task automatic cyc(input bit r, input bit rdy, input bit g, input bit rd,
                     input logic [31:0] rpc, input int lat);
    bit exp_req, rv;
    logic [31:0] rdat;
    int o0, due;
    @(negedge clk);
    rst_i = r; ready_i = rdy; mem_gnt_i = g; redirect_i = rd; redirect_pc_i = rpc;
    rv = r && mq.size() > 0 && mq[0].due <= cyc_n;
    rdat = rv ? (mq[0].addr >> 2) : $urandom;
    mem_rvalid_i = rv; mem_rdata_i = rdat;
    #1;
    exp_req = r && !rd && (q.size() + m_out + m_disc < DEPTH);
    if (mem_req_o === 1'b1 && g) nfire++;
    if (inited) begin
      chk("mem_req", {31'b0, mem_req_o}, {31'b0, exp_req});
      chk("mem_addr", mem_addr_o, m_fpc);
      chk("valid", {31'b0, valid_o}, {31'b0, q.size() > 0});
      if (q.size() > 0) begin
        chk("pc", pc_o, q[0].pc);
        chk("instr", instr_o, q[0].instr);
        chk("pc4", pc4_o, q[0].pc + 32'd4);
      end
      if (just_rst) begin
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
      end
    end
    @(posedge clk);
    // memory side
    if (!r) begin
      mq.delete(); last_due = 0;
    end else begin
      if (rv) void'(mq.pop_front());
      if (exp_req && g) begin
        due = cyc_n + lat;
        if (due < last_due) due = last_due;
        last_due = due;
        mq.push_back('{addr: m_fpc, due: due});
      end
    end
    // fetch-queue rules
    if (!r) begin
      q.delete(); m_fpc = RESET_PC; m_rpc = RESET_PC;
      m_out = 0; m_disc = 0; inited = 1; just_rst = 1;
    end else begin
      just_rst = 0;
      if (rd) begin
        q.delete();
        m_disc = m_disc + m_out - ((rv && (m_disc + m_out) > 0) ? 1 : 0);
        m_out = 0;
        m_fpc = rpc & ~32'h3; m_rpc = m_fpc;
      end else begin
        o0 = m_out;
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (rv) begin
          if (m_disc > 0) m_disc--;
          else if (o0 > 0) begin
            q.push_back('{instr: rdat, pc: m_rpc});
            m_rpc += 32'd4; m_out--;
          end
        end
        if (exp_req && g) begin m_fpc += 32'd4; m_out++; end
      end
    end
    cyc_n++;
  endtask

  initial begin
    // 1: streaming from RESET_PC, wraps through 0; 1-cycle memory
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 1, 1, 0, 0, 1);

    // 2: consumer stalled -> exactly DEPTH requests, then one more per pop
    cyc(0, 0, 0, 0, 0, 1);
    nfire = 0;
    for (int i = 0; i < 12; i++) cyc(1, 0, 1, 0, 0, 1);
    chk("stall_reqs", nfire, DEPTH);
    cyc(1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 1, 0, 0, 1);
    chk("one_more_req", nfire, DEPTH + 1);

    // 3: 3-cycle memory, redirect to 0x100 with responses in flight
    cyc(0, 0, 0, 0, 0, 3);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 3);
    cyc(1, 1, 1, 1, 32'h100, 3);
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 0, 0, 3);

    // 4: redirect to 0x103 alongside a pop and a response
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 1, 1, 0, 0, 1);
    cyc(1, 1, 1, 1, 32'h103, 1);
    for (int i = 0; i < 8; i++) cyc(1, 1, 1, 0, 0, 1);

    // back-to-back redirects
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0, 2);
    cyc(1, 0, 1, 1, 32'h2000, 2);
    cyc(1, 0, 1, 1, 32'h3000, 2);
    for (int i = 0; i < 10; i++) cyc(1, 1, 1, 0, 0, 2);

    // 6: reset mid-stream with requests outstanding
    for (int i = 0; i < 2; i++) cyc(1, 0, 1, 0, 0, 3);
    cyc(0, 1, 1, 0, 0, 3);
    for (int i = 0; i < 10; i++) cyc(1, 1, 1, 0, 0, 3);

    // random traffic
    for (int i = 0; i < 4000; i++)
      cyc(($urandom % 200) != 0, ($urandom % 3) != 0, ($urandom % 4) != 0,
          ($urandom % 25) == 0, $urandom, 1 + int'($urandom % 4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
